des_expansion_contract: RTL and testbench

- Inverse of the DES E-box expansion stage: accepts 48-bit expanded words and recovers the original 32-bit half-block.
- Checks all 16 duplicated bits produced by the expansion for consistency.
- Streams through a valid/ready interface with a 2-entry skid buffer. Keeps a saturating count of inconsistent words.
- Sits in the DES core's self-check and debug path, after the expansion stage output.

---
 rtl/des_expansion_contract.sv | 130 +++++++++++++
 tb/tb_des_expansion_contract.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_expansion_contract.sv
// des_expansion_contract
// Undoes the DES E-box expansion: takes a 48-bit expanded word, recovers the
// 32-bit half-block and flags every duplicated bit that disagrees with its twin.
// Results stream out through a 2-entry skid buffer. A saturating counter
// tracks how many inconsistent words were accepted.
module des_expansion_contract #(
   parameter int DROP_ERR = 0,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [47:0]      in_dat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_dat,
   output logic             out_err,
   output logic [15:0]      out_mask,
   output logic [CNT_W-1:0] err_cnt,
   input  logic             cnt_clr
);

   // A buffer entry holds {err, mask[15:0], dat[31:0]}.
   localparam int EW = 49;

   logic [31:0]      rec_dat;
   logic [15:0]      rec_mask;
   logic             rec_err;
   logic [EW-1:0]    rec_entry;

   logic [EW-1:0]    slot0_reg, slot0_next;
   logic [EW-1:0]    slot1_reg, slot1_next;
   logic [1:0]       count_reg, count_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   logic             full;
   logic             accept;
   logic             keep;
   logic             pop;

   // Outer bits of the half-block come from the wrap-around group and the
   // last group. The six middle groups each carry four fresh bits.
   assign rec_dat[31:27] = in_dat[46:42];
   assign rec_dat[2:0]   = in_dat[3:1];

   genvar gi;
   generate
      for (gi = 0; gi < 6; gi++) begin : g_rec
         assign rec_dat[26-4*gi -: 4] = in_dat[39-6*gi -: 4];
      end
   endgenerate

   // The two wrap-around duplicates (d0 and d31) are compared here.
   // The generate loop below compares the 14 edge duplicates shared by
   // adjacent groups.
   assign rec_mask[0] = in_dat[47] ^ in_dat[1];
   assign rec_mask[1] = in_dat[0]  ^ in_dat[46];

   generate
      for (gi = 0; gi < 7; gi++) begin : g_mask
         assign rec_mask[2+2*gi] = in_dat[40-6*gi] ^ in_dat[42-6*gi];
         assign rec_mask[3+2*gi] = in_dat[41-6*gi] ^ in_dat[43-6*gi];
      end
   endgenerate

   assign rec_err   = |rec_mask;
   assign rec_entry = {rec_err, rec_mask, rec_dat};

   // in_ready is held low while reset is asserted, so nothing is accepted
   // during the reset cycle.
   assign full     = (count_reg == 2'd2);
   assign in_ready = !full && !rst;
   assign accept   = in_valid && in_ready;
   // A dropped word still completes its handshake. It is not stored.
   assign keep     = accept && !((DROP_ERR != 0) && rec_err);
   assign pop      = (count_reg != 2'd0) && out_ready;

   assign out_valid = (count_reg != 2'd0);
   assign out_err   = slot0_reg[48];
   assign out_mask  = slot0_reg[47:32];
   assign out_dat   = slot0_reg[31:0];
   assign err_cnt   = cnt_reg;

   // Buffer next state: pop shifts slot1 into the head. Push fills the first
   // free slot after the pop, so push and pop with one entry replaces the head.
   always_comb begin
      slot0_next = slot0_reg;
      slot1_next = slot1_reg;
      count_next = count_reg;
      if (pop) begin
         slot0_next = slot1_reg;
         count_next = count_reg - 2'd1;
      end
      if (keep) begin
         if (count_next == 2'd0) begin
            slot0_next = rec_entry;
         end else begin
            slot1_next = rec_entry;
         end
         count_next = count_next + 2'd1;
      end
   end

   // Saturating error counter. A clear wins over an increment in the same cycle.
   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr) begin
         cnt_next = '0;
      end else if (accept && rec_err && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   // State registers. Reset empties the buffer and clears all outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_reg <= '0;
         slot1_reg <= '0;
         count_reg <= 2'd0;
         cnt_reg   <= '0;
      end else begin
         slot0_reg <= slot0_next;
         slot1_reg <= slot1_next;
         count_reg <= count_next;
         cnt_reg   <= cnt_next;
      end
   end

endmodule

// File: tb/tb_des_expansion_contract.sv
// tb_des_expansion_contract
// Directed test of des_expansion_contract. dut_a forwards bad words and uses
// a 16-bit counter. dut_b drops bad words and uses a 2-bit counter.
// Both instances share the same stimulus.
module tb_des_expansion_contract;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [47:0] in_dat;
   logic        out_ready;
   logic        cnt_clr;

   logic        a_in_ready, a_out_valid, a_out_err;
   logic [31:0] a_out_dat;
   logic [15:0] a_out_mask;
   logic [15:0] a_err_cnt;

   logic        b_in_ready, b_out_valid, b_out_err;
   logic [31:0] b_out_dat;
   logic [15:0] b_out_mask;
   logic [1:0]  b_err_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   des_expansion_contract #(.DROP_ERR(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_dat(in_dat), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_dat(a_out_dat), .out_err(a_out_err), .out_mask(a_out_mask),
      .err_cnt(a_err_cnt), .cnt_clr(cnt_clr)
   );

   des_expansion_contract #(.DROP_ERR(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_dat(in_dat), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_dat(b_out_dat), .out_err(b_out_err), .out_mask(b_out_mask),
      .err_cnt(b_err_cnt), .cnt_clr(cnt_clr)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [47:0] e);
      in_dat   = e;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      #1;
   endtask

   // Forward E-box in this block's bit numbering. The design inverts this mapping.
   function automatic logic [47:0] expand(input logic [31:0] d);
      return {d[0], d[31:27], d[28:23], d[24:19], d[20:15],
              d[16:11], d[12:7], d[8:3], d[4:0], d[31]};
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_dat = '0; out_ready = 1'b1; cnt_clr = 1'b0;

      // Check the reset state of both instances.
      tick();
      tick();
      check("rst_in_ready", a_in_ready, 0);
      check("rst_out_valid", a_out_valid, 0);
      check("rst_out_dat", a_out_dat, 0);
      check("rst_out_err", a_out_err, 0);
      check("rst_out_mask", a_out_mask, 0);
      check("rst_err_cnt", a_err_cnt, 0);
      check("rst_b_out_valid", b_out_valid, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", a_in_ready, 1);

      // Consistent words with out_ready held high, so latency is one cycle.
      push_one(48'h8000_0000_0002);
      check("one_valid", a_out_valid, 1);
      check("one_dat", a_out_dat, 32'h0000_0001);
      check("one_err", a_out_err, 0);
      check("one_mask", a_out_mask, 0);
      check("one_cnt", a_err_cnt, 0);
      check("one_b_dat", b_out_dat, 32'h0000_0001);
      tick();
      check("one_drained", a_out_valid, 0);

      push_one(48'h4000_0000_0001);
      check("msb_dat", a_out_dat, 32'h8000_0000);
      check("msb_err", a_out_err, 0);
      tick();

      push_one(48'hFFFF_FFFF_FFFF);
      check("ones_dat", a_out_dat, 32'hFFFF_FFFF);
      check("ones_mask", a_out_mask, 0);
      tick();

      push_one(expand(32'h1234_5678));
      check("mixed_dat", a_out_dat, 32'h1234_5678);
      check("mixed_err", a_out_err, 0);
      tick();

      // Corrupted duplicates. dut_a forwards each bad word and dut_b drops it.
      push_one(48'h7FFF_FFFF_FFFF);
      check("bad47_valid", a_out_valid, 1);
      check("bad47_dat", a_out_dat, 32'hFFFF_FFFF);
      check("bad47_err", a_out_err, 1);
      check("bad47_mask", a_out_mask, 16'h0001);
      check("bad47_cnt", a_err_cnt, 1);
      check("bad47_b_valid", b_out_valid, 0);
      check("bad47_b_cnt", b_err_cnt, 1);
      tick();

      push_one(48'h0000_0000_0001);
      check("bad0_dat", a_out_dat, 32'h0000_0000);
      check("bad0_mask", a_out_mask, 16'h0002);
      check("bad0_cnt", a_err_cnt, 2);
      tick();

      push_one(48'h0000_0100_0000);
      check("bad24_dat", a_out_dat, 32'h0000_8000);
      check("bad24_mask", a_out_mask, 16'h0100);
      check("bad24_cnt", a_err_cnt, 3);
      check("bad24_b_cnt", b_err_cnt, 3);
      tick();

      // Clear the counters, then send five back-to-back bad words.
      // The 2-bit counter should saturate at 3.
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      check("clr_a_cnt", a_err_cnt, 0);
      check("clr_b_cnt", b_err_cnt, 0);
      for (int i = 1; i <= 5; i++) begin
         in_dat   = 48'h7FFF_FFFF_FFFF;
         in_valid = 1'b1;
         #1;
         check($sformatf("stream%0d_in_ready", i), a_in_ready, 1);
         tick();
         check($sformatf("stream%0d_a_cnt", i), a_err_cnt, i);
         check($sformatf("stream%0d_b_cnt", i), b_err_cnt, (i > 3) ? 3 : i);
         check($sformatf("stream%0d_a_valid", i), a_out_valid, 1);
      end
      // A clear in the same cycle as a sixth bad word wins over the increment.
      cnt_clr = 1'b1;
      tick();
      cnt_clr  = 1'b0;
      in_valid = 1'b0;
      check("clr6_a_cnt", a_err_cnt, 0);
      check("clr6_b_cnt", b_err_cnt, 0);
      tick();
      check("stream_drained", a_out_valid, 0);

      // Backpressure: fill both slots, hold the head stable, then drain in order.
      out_ready = 1'b0;
      in_dat    = 48'h8000_0000_0002;
      in_valid  = 1'b1;
      tick();
      check("bp_a_ready1", a_in_ready, 1);
      check("bp_a_head1", a_out_dat, 32'h0000_0001);
      in_dat = 48'h4000_0000_0001;
      tick();
      in_valid = 1'b0;
      check("bp_full_ready", a_in_ready, 0);
      check("bp_full_b_ready", b_in_ready, 0);
      check("bp_head", a_out_dat, 32'h0000_0001);
      tick();
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_dat", a_out_dat, 32'h0000_0001);
      out_ready = 1'b1;
      tick();
      check("bp_second_dat", a_out_dat, 32'h8000_0000);
      check("bp_second_valid", a_out_valid, 1);
      check("bp_ready_back", a_in_ready, 1);
      tick();
      check("bp_empty", a_out_valid, 0);

      // Reset while two words are buffered.
      out_ready = 1'b0;
      in_dat    = 48'h7FFF_FFFF_FFFF;
      in_valid  = 1'b1;
      tick();
      in_dat = 48'hFFFF_FFFF_FFFF;
      tick();
      in_valid = 1'b0;
      check("mid_a_cnt", a_err_cnt, 1);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", a_in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_a_valid", a_out_valid, 0);
      check("mid_rst_a_cnt", a_err_cnt, 0);
      check("mid_rst_b_valid", b_out_valid, 0);
      check("mid_rst_b_cnt", b_err_cnt, 0);
      out_ready = 1'b1;
      push_one(48'h8000_0000_0002);
      check("after_rst_valid", a_out_valid, 1);
      check("after_rst_dat", a_out_dat, 32'h0000_0001);
      tick();
      check("after_rst_alone", a_out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
